// File: rtl/ysyx_25010008_reg_scoreboard.sv
// GPR file with pending-write scoreboard, writeback bypass and a minimal machine-mode CSR set.
// Out-of-range or x0 indices read as zero and are never reserved or written.
module ysyx_25010008_reg_scoreboard #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] src1,
    output logic [XLEN-1:0] src2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            issue_wen,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            wb_wen,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            csr_wen,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            ecall,
    input  logic            mret,
    input  logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out
);

    localparam int AW = $clog2(NREGS);

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    logic [XLEN-1:0]  gpr [NREGS];
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0]  mstatus;
    logic [XLEN-1:0]  mtvec;
    logic [XLEN-1:0]  mepc;
    logic [XLEN-1:0]  mcause;
    logic [63:0]      mcycle;
    logic [63:0]      minstret;

    logic            wb_hit;
    logic            issue_hit;
    logic [AW-1:0]   wb_idx;
    logic [AW-1:0]   issue_idx;
    logic            csr_we;
    logic            take_trap;
    logic            take_ret;

    function automatic logic in_range(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NREGS);
    endfunction

    assign wb_hit    = !reset && wb_valid && wb_wen && in_range(wb_rd);
    assign issue_hit = !reset && issue_valid && issue_wen && in_range(issue_rd);
    assign wb_idx    = wb_rd[AW-1:0];
    assign issue_idx = issue_rd[AW-1:0];

    assign csr_we    = wb_valid && csr_wen;
    assign take_trap = wb_valid && ecall;
    assign take_ret  = wb_valid && mret && !ecall;

    // A same-cycle issue to the bypassed register keeps it reported busy.
    always_comb begin
        src1     = '0;
        rs1_busy = 1'b0;
        if (in_range(rs1)) begin
            if (wb_hit && wb_rd == rs1) begin
                src1     = wb_data;
                rs1_busy = issue_hit && (issue_rd == rs1);
            end else begin
                src1     = gpr[rs1[AW-1:0]];
                rs1_busy = busy[rs1[AW-1:0]];
            end
        end
    end

    always_comb begin
        src2     = '0;
        rs2_busy = 1'b0;
        if (in_range(rs2)) begin
            if (wb_hit && wb_rd == rs2) begin
                src2     = wb_data;
                rs2_busy = issue_hit && (issue_rd == rs2);
            end else begin
                src2     = gpr[rs2[AW-1:0]];
                rs2_busy = busy[rs2[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_hit) begin
                gpr[wb_idx] <= wb_data;
            end
            if (flush) begin
                busy <= '0;
            end else begin
                if (wb_hit) begin
                    busy[wb_idx] <= 1'b0;
                end
                if (issue_hit) begin
                    busy[issue_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && csr_waddr == CSR_MCYCLE) begin
                mcycle[31:0] <= csr_wdata[31:0];
            end else if (csr_we && csr_waddr == CSR_MCYCLEH) begin
                mcycle[63:32] <= csr_wdata[31:0];
            end else begin
                mcycle <= mcycle + 64'd1;
            end

            if (csr_we && csr_waddr == CSR_MINSTRET) begin
                minstret[31:0] <= csr_wdata[31:0];
            end else if (csr_we && csr_waddr == CSR_MINSTRETH) begin
                minstret[63:32] <= csr_wdata[31:0];
            end else if (wb_valid) begin
                minstret <= minstret + 64'd1;
            end
        end
    end

    // Trap entry/return own mstatus, mepc and mcause for the cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus <= XLEN'(32'h0000_1800);
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            if (csr_we && csr_waddr == CSR_MTVEC) begin
                mtvec <= csr_wdata;
            end
            if (take_trap) begin
                mepc            <= trap_pc;
                mcause          <= XLEN'(32'd11);
                mstatus[12:11]  <= 2'b11;
                mstatus[7]      <= mstatus[3];
                mstatus[3]      <= 1'b0;
            end else if (take_ret) begin
                mstatus[3] <= mstatus[7];
                mstatus[7] <= 1'b1;
            end else if (csr_we) begin
                if (csr_waddr == CSR_MSTATUS) begin
                    mstatus <= csr_wdata;
                end
                if (csr_waddr == CSR_MEPC) begin
                    mepc <= csr_wdata;
                end
                if (csr_waddr == CSR_MCAUSE) begin
                    mcause <= csr_wdata;
                end
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = mstatus;
            CSR_MTVEC:     csr_rdata = mtvec;
            CSR_MEPC:      csr_rdata = mepc;
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MCYCLE:    csr_rdata = XLEN'(mcycle[31:0]);
            CSR_MCYCLEH:   csr_rdata = XLEN'(mcycle[63:32]);
            CSR_MINSTRET:  csr_rdata = XLEN'(minstret[31:0]);
            CSR_MINSTRETH: csr_rdata = XLEN'(minstret[63:32]);
            default:       csr_rdata = '0;
        endcase
    end

    assign mtvec_out = mtvec;
    assign mepc_out  = mepc;

endmodule

// File: tb/tb_ysyx_25010008_reg_scoreboard.sv
// Scoreboard bench: the driver pushes model-predicted outputs per cycle, a negedge monitor pops and compares.
module tb_ysyx_25010008_reg_scoreboard;

    localparam int NREGS = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2;
    logic [31:0] src1, src2;
    logic        rs1_busy, rs2_busy;
    logic        issue_valid, issue_wen;
    logic [4:0]  issue_rd;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [11:0] csr_raddr, csr_waddr;
    logic [31:0] csr_rdata, csr_wdata;
    logic        csr_wen, ecall, mret;
    logic [31:0] trap_pc, mtvec_out, mepc_out;

    ysyx_25010008_reg_scoreboard #(.NREGS(NREGS), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .rs1(rs1), .rs2(rs2), .src1(src1), .src2(src2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .flush(flush),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .ecall(ecall), .mret(mret), .trap_pc(trap_pc),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] src1, src2;
        logic        b1, b2;
        logic [31:0] csr, mtvec, mepc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Architectural reference state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    logic [11:0] csr_list [10] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00,
                                   12'hB80, 12'hB02, 12'hB82, 12'h123, 12'hFFF};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit gpr_ok(input logic [4:0] r);
        return r != 5'd0 && int'(r) < NREGS;
    endfunction

    function automatic bit wb_writes(input logic [4:0] r);
        return !reset && wb_valid && wb_wen && gpr_ok(r) && wb_rd == r;
    endfunction

    function automatic logic [31:0] exp_src(input logic [4:0] r);
        if (!gpr_ok(r)) return 32'd0;
        if (wb_writes(r)) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic exp_busy(input logic [4:0] r);
        if (!gpr_ok(r)) return 1'b0;
        if (wb_writes(r)) return issue_valid && issue_wen && issue_rd == r;
        return m_busy[r];
    endfunction

    function automatic logic [31:0] exp_csr(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_exp();
        exp_t e;
        e.src1  = exp_src(rs1);
        e.src2  = exp_src(rs2);
        e.b1    = exp_busy(rs1);
        e.b2    = exp_busy(rs2);
        e.csr   = exp_csr(csr_raddr);
        e.mtvec = m_mtvec;
        e.mepc  = m_mepc;
        q.push_back(e);
    endtask

    task automatic model_next();
        logic [31:0] ms;
        bit cw, trap, ret;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
            m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
            m_mcycle = 0; m_minstret = 0;
            return;
        end
        cw   = wb_valid && csr_wen;
        trap = wb_valid && ecall;
        ret  = wb_valid && mret && !ecall;
        if (wb_valid && wb_wen && gpr_ok(wb_rd)) m_regs[wb_rd] = wb_data;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (wb_valid && wb_wen && gpr_ok(wb_rd)) m_busy[wb_rd] = 1'b0;
            if (issue_valid && issue_wen && gpr_ok(issue_rd)) m_busy[issue_rd] = 1'b1;
        end
        if (cw && csr_waddr == 12'hB00)      m_mcycle = {m_mcycle[63:32], csr_wdata};
        else if (cw && csr_waddr == 12'hB80) m_mcycle = {csr_wdata, m_mcycle[31:0]};
        else                                 m_mcycle = m_mcycle + 1;
        if (cw && csr_waddr == 12'hB02)      m_minstret = {m_minstret[63:32], csr_wdata};
        else if (cw && csr_waddr == 12'hB82) m_minstret = {csr_wdata, m_minstret[31:0]};
        else if (wb_valid)                   m_minstret = m_minstret + 1;
        if (cw && csr_waddr == 12'h305) m_mtvec = csr_wdata;
        ms = m_mstatus;
        if (trap) begin
            m_mepc = trap_pc;
            m_mcause = 32'd11;
            ms[7] = m_mstatus[3];
            ms[3] = 1'b0;
            ms[12:11] = 2'b11;
        end else if (ret) begin
            ms[3] = m_mstatus[7];
            ms[7] = 1'b1;
        end else if (cw) begin
            if (csr_waddr == 12'h300) ms = csr_wdata;
            if (csr_waddr == 12'h341) m_mepc = csr_wdata;
            if (csr_waddr == 12'h342) m_mcause = csr_wdata;
        end
        m_mstatus = ms;
    endtask

    task automatic clear_inputs();
        reset = 0; rs1 = 0; rs2 = 0;
        issue_valid = 0; issue_rd = 0; issue_wen = 0;
        wb_valid = 0; wb_rd = 0; wb_wen = 0; wb_data = 0;
        flush = 0; csr_raddr = 0; csr_wen = 0; csr_waddr = 0; csr_wdata = 0;
        ecall = 0; mret = 0; trap_pc = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_next();
        #1;
    endtask

    task automatic settle_push();
        push_exp();
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        clear_inputs();
        wb_valid = 1; csr_wen = 1; csr_waddr = a; csr_wdata = d;
        settle_push();
        tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("src1", src1, e.src1);
                chk("src2", src2, e.src2);
                chk("rs1_busy", rs1_busy, e.b1);
                chk("rs2_busy", rs2_busy, e.b2);
                chk("csr_rdata", csr_rdata, e.csr);
                chk("mtvec_out", mtvec_out, e.mtvec);
                chk("mepc_out", mepc_out, e.mepc);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : driver
        clear_inputs();
        reset = 1;
        tick();
        tick();
        clear_inputs();

        // first post-reset cycle
        rs1 = 3; rs2 = 5; csr_raddr = 12'hB00;
        settle_push();
        chk("reset_mcycle", csr_rdata, 32'd0);
        chk("reset_src1", src1, 32'd0);
        chk("reset_busy", rs1_busy, 1'b0);
        tick();
        csr_raddr = 12'hB00;
        settle_push();
        chk("mcycle_incr", csr_rdata, 32'd1);
        tick();
        csr_raddr = 12'h300;
        settle_push();
        chk("reset_mstatus", csr_rdata, 32'h1800);
        tick();

        // reserve, observe busy, then writeback bypass
        clear_inputs(); issue_valid = 1; issue_wen = 1; issue_rd = 5;
        settle_push(); tick();
        clear_inputs(); rs1 = 5;
        settle_push();
        chk("busy_after_issue", rs1_busy, 1'b1);
        tick();
        clear_inputs(); rs1 = 5; wb_valid = 1; wb_wen = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        settle_push();
        chk("bypass_src1", src1, 32'hDEADBEEF);
        chk("bypass_busy", rs1_busy, 1'b0);
        tick();

        // same-cycle issue and writeback, then flush
        clear_inputs(); issue_valid = 1; issue_wen = 1; issue_rd = 7;
        wb_valid = 1; wb_wen = 1; wb_rd = 7; wb_data = 32'h1234; rs2 = 7;
        settle_push();
        chk("issue_wins_busy", rs2_busy, 1'b1);
        tick();
        clear_inputs(); rs1 = 7; flush = 1;
        settle_push();
        chk("issue_wb_src", src1, 32'h1234);
        chk("issue_wb_busy", rs1_busy, 1'b1);
        tick();
        clear_inputs(); rs1 = 7;
        settle_push();
        chk("flush_busy", rs1_busy, 1'b0);
        tick();

        // out-of-range writeback
        clear_inputs(); wb_valid = 1; wb_wen = 1; wb_rd = 20; wb_data = 32'hFF; rs1 = 20; rs2 = 4;
        settle_push();
        chk("oor_src", src1, 32'd0);
        chk("oor_busy", rs1_busy, 1'b0);
        tick();
        clear_inputs(); rs1 = 20; rs2 = 4;
        settle_push();
        chk("oor_src_after", src1, 32'd0);
        chk("oor_r4", src2, 32'd0);
        tick();

        // trap entry and return
        csr_write(12'h300, 32'h1808);
        clear_inputs(); wb_valid = 1; ecall = 1; trap_pc = 32'h80000010;
        csr_wen = 1; csr_waddr = 12'h341; csr_wdata = 32'h5555;
        settle_push(); tick();
        clear_inputs(); csr_raddr = 12'h341;
        settle_push();
        chk("ecall_mepc", csr_rdata, 32'h80000010);
        chk("ecall_mepc_out", mepc_out, 32'h80000010);
        tick();
        clear_inputs(); csr_raddr = 12'h342;
        settle_push();
        chk("ecall_mcause", csr_rdata, 32'd11);
        tick();
        clear_inputs(); csr_raddr = 12'h300;
        settle_push();
        chk("ecall_mstatus", csr_rdata, 32'h1880);
        tick();
        clear_inputs(); wb_valid = 1; mret = 1;
        settle_push(); tick();
        clear_inputs(); csr_raddr = 12'h300;
        settle_push();
        chk("mret_mstatus", csr_rdata, 32'h1888);
        tick();

        // 64-bit mcycle wrap
        csr_write(12'hB00, 32'hFFFFFFFF);
        csr_write(12'hB80, 32'hFFFFFFFF);
        clear_inputs(); csr_raddr = 12'hB00;
        settle_push();
        chk("mcycle_all_ones", csr_rdata, 32'hFFFFFFFF);
        tick();
        clear_inputs(); csr_raddr = 12'hB00;
        settle_push();
        chk("mcycle_wrap_lo", csr_rdata, 32'd0);
        tick();
        clear_inputs(); csr_raddr = 12'hB80;
        settle_push();
        chk("mcycle_wrap_hi", csr_rdata, 32'd0);
        tick();

        // reset aborts reservations
        for (int r = 1; r <= 3; r++) begin
            clear_inputs(); issue_valid = 1; issue_wen = 1; issue_rd = 5'(r);
            settle_push(); tick();
        end
        clear_inputs(); reset = 1; issue_valid = 1; issue_wen = 1; issue_rd = 4;
        wb_valid = 1; csr_wen = 1; csr_waddr = 12'h305; csr_wdata = 32'hABCD;
        settle_push(); tick();
        clear_inputs(); rs1 = 2; rs2 = 4; csr_raddr = 12'h300;
        settle_push();
        chk("rst_busy", rs1_busy, 1'b0);
        chk("rst_busy_ignored_issue", rs2_busy, 1'b0);
        chk("rst_mstatus", csr_rdata, 32'h1800);
        chk("rst_mtvec", mtvec_out, 32'd0);
        tick();
        clear_inputs(); rs1 = 5; rs2 = 7;
        settle_push();
        chk("rst_gpr5", src1, 32'd0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            rs1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rs2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            issue_valid = $urandom_range(0, 1);
            issue_wen   = $urandom_range(0, 3) != 0;
            issue_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wb_valid    = $urandom_range(0, 1);
            wb_wen      = $urandom_range(0, 3) != 0;
            wb_rd       = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            flush       = $urandom_range(0, 15) == 0;
            csr_raddr   = csr_list[$urandom_range(0, 9)];
            csr_wen     = $urandom_range(0, 5) == 0;
            csr_waddr   = csr_list[$urandom_range(0, 9)];
            csr_wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            ecall       = $urandom_range(0, 15) == 0;
            mret        = $urandom_range(0, 15) == 0;
            trap_pc     = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                wb_valid = 0;
            end
            settle_push();
            tick();
        end

        clear_inputs();
        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
